// File: rtl/pic_irr.sv
// Interrupt Request Register of an 8259-style PIC: latches IR lines in level or
// rising-edge mode, holds pending requests and presents the unmasked ones.
module pic_irr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Level_Edge_flag,
    input  logic [WIDTH-1:0] Mask,
    input  logic [WIDTH-1:0] I_WIRES,
    input  logic [WIDTH-1:0] Clear_IRR,
    output logic [WIDTH-1:0] IRR,
    output logic             INT_REQ
);

    logic [WIDTH-1:0] irr_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irr_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        irr_d = irr_q;
        rise  = I_WIRES & ~prev_q;
        if (Level_Edge_flag) begin
            // A fresh rising edge outranks a clear arriving in the same cycle.
            irr_d = rise | (irr_q & ~Clear_IRR);
        end else begin
            irr_d = I_WIRES & ~Clear_IRR;
        end
    end

    // prev_q resets to all-ones so a line already high at reset release must
    // toggle low then high before it counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            irr_q  <= '0;
            prev_q <= '1;
        end else begin
            irr_q  <= irr_d;
            prev_q <= I_WIRES;
        end
    end

    // Masking only gates the output; pending bits keep latching underneath.
    assign IRR     = irr_q & ~Mask;
    assign INT_REQ = |IRR;

endmodule

// File: tb/tb_pic_irr.sv
// Self-checking bench for pic_irr: directed scenarios plus randomized traffic
// compared against a per-line behavioural model of request latching.
module tb_pic_irr;

    logic       clk;
    logic       rst_n;
    logic       Level_Edge_flag;
    logic [7:0] Mask;
    logic [7:0] I_WIRES;
    logic [7:0] Clear_IRR;
    logic [7:0] IRR;
    logic       INT_REQ;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    // Reference model: one pending flag and one "last seen level" per line.
    bit pending [8];
    bit last_lvl[8];

    pic_irr #(.WIDTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Level_Edge_flag (Level_Edge_flag),
        .Mask            (Mask),
        .I_WIRES         (I_WIRES),
        .Clear_IRR       (Clear_IRR),
        .IRR             (IRR),
        .INT_REQ         (INT_REQ)
    );

    initial clk = 1'b0;
    always #5 if (run) clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            pending[i]  = 1'b0;
            last_lvl[i] = 1'b1;
        end
    endfunction

    function automatic logic [7:0] exp_irr();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v[i] = pending[i] && !Mask[i];
        return v;
    endfunction

    // Advance one clock: the model decides each line's fate from the inputs
    // present at the edge, then outputs are sampled 1 time unit later.
    task automatic tick();
        bit nxt[8];
        for (int i = 0; i < 8; i++) begin
            bit line_hi, cleared, went_up;
            line_hi = I_WIRES[i];
            cleared = Clear_IRR[i];
            went_up = line_hi && !last_lvl[i];
            if (Level_Edge_flag)
                nxt[i] = went_up ? 1'b1 : (cleared ? 1'b0 : pending[i]);
            else
                nxt[i] = cleared ? 1'b0 : line_hi;
        end
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            pending[i]  = nxt[i];
            last_lvl[i] = I_WIRES[i];
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Level_Edge_flag = 1'b0;
        Mask      = 8'h00;
        I_WIRES   = 8'hFF;
        Clear_IRR = 8'h00;
        rst_n     = 1'b0;
        model_reset();
        #1;
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL reset_irr got %h want 00", IRR); end
        checks++;
        if (INT_REQ !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", INT_REQ); end
        // Inputs are ignored while reset is held, even with the clock running.
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL reset_held_irr got %h want 00", IRR); end
        // Edge mode with lines already high at release: no edge is seen.
        Level_Edge_flag = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (IRR !== 8'h00 || IRR !== exp_irr()) begin
            errors++; $display("FAIL reset_release_edge got %h want 00", IRR);
        end
    endtask

    task automatic test_level();
        do_reset();
        Level_Edge_flag = 1'b0;
        Mask    = 8'hCC;
        I_WIRES = 8'hAA;
        tick();
        checks++;
        if (IRR !== 8'h22) begin errors++; $display("FAIL level_set got %h want 22", IRR); end
        checks++;
        if (INT_REQ !== 1'b1) begin errors++; $display("FAIL level_int got %b want 1", INT_REQ); end
        I_WIRES = 8'h00;
        tick();
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL level_drop got %h want 00", IRR); end
        checks++;
        if (INT_REQ !== 1'b0) begin errors++; $display("FAIL level_drop_int got %b want 0", INT_REQ); end
    endtask

    task automatic test_edge();
        do_reset();
        Level_Edge_flag = 1'b1;
        Mask    = 8'h33;
        I_WIRES = 8'h00;
        tick();
        I_WIRES = 8'hCC;
        tick();
        checks++;
        if (IRR !== 8'hCC) begin errors++; $display("FAIL edge_rise got %h want cc", IRR); end
        I_WIRES = 8'h00;
        tick();
        checks++;
        if (IRR !== 8'hCC) begin errors++; $display("FAIL edge_hold got %h want cc", IRR); end
        Clear_IRR = 8'h04;
        tick();
        Clear_IRR = 8'h00;
        checks++;
        if (IRR !== 8'hC8) begin errors++; $display("FAIL edge_clear got %h want c8", IRR); end
    endtask

    task automatic test_edge_held();
        do_reset();
        Level_Edge_flag = 1'b1;
        Mask    = 8'h00;
        I_WIRES = 8'h00;
        tick();
        I_WIRES = 8'h01;
        tick();
        checks++;
        if (IRR !== 8'h01) begin errors++; $display("FAIL held_rise got %h want 01", IRR); end
        Clear_IRR = 8'h01;
        tick();
        Clear_IRR = 8'h00;
        repeat (3) begin
            checks++;
            if (IRR !== 8'h00) begin errors++; $display("FAIL held_no_rereq got %h want 00", IRR); end
            tick();
        end
        I_WIRES = 8'h00;
        tick();
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL held_low got %h want 00", IRR); end
        I_WIRES = 8'h01;
        tick();
        checks++;
        if (IRR !== 8'h01) begin errors++; $display("FAIL held_retoggle got %h want 01", IRR); end
    endtask

    task automatic test_collision();
        do_reset();
        Level_Edge_flag = 1'b0;
        Mask      = 8'h00;
        I_WIRES   = 8'h10;
        Clear_IRR = 8'h10;
        tick();
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL coll_level_clear got %h want 00", IRR); end
        Clear_IRR = 8'h00;
        tick();
        checks++;
        if (IRR !== 8'h10) begin errors++; $display("FAIL coll_level_reassert got %h want 10", IRR); end
        // Mode switch keeps the pending bit.
        Level_Edge_flag = 1'b1;
        I_WIRES   = 8'h00;
        tick();
        checks++;
        if (IRR !== 8'h10) begin errors++; $display("FAIL coll_mode_keep got %h want 10", IRR); end
        Clear_IRR = 8'h10;
        tick();
        checks++;
        if (IRR !== 8'h00) begin errors++; $display("FAIL coll_edge_clear got %h want 00", IRR); end
        I_WIRES   = 8'h10;
        tick();
        Clear_IRR = 8'h00;
        checks++;
        if (IRR !== 8'h10) begin errors++; $display("FAIL coll_edge_wins got %h want 10", IRR); end
    endtask

    task automatic test_mask_live();
        do_reset();
        Level_Edge_flag = 1'b0;
        Mask    = 8'hFF;
        I_WIRES = 8'hFF;
        tick();
        checks++;
        if (IRR !== 8'h00 || INT_REQ !== 1'b0) begin
            errors++; $display("FAIL mask_all got %h/%b want 00/0", IRR, INT_REQ);
        end
        Mask = 8'h0F;
        #1;
        checks++;
        if (IRR !== 8'hF0) begin errors++; $display("FAIL mask_live got %h want f0", IRR); end
        checks++;
        if (INT_REQ !== 1'b1) begin errors++; $display("FAIL mask_live_int got %b want 1", INT_REQ); end
    endtask

    task automatic test_random();
        logic [7:0] want;
        do_reset();
        Level_Edge_flag = 1'($urandom_range(0, 1));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) Level_Edge_flag = ~Level_Edge_flag;
            I_WIRES   = 8'($urandom);
            Clear_IRR = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            Mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            tick();
            want = exp_irr();
            checks++;
            if (IRR !== want || INT_REQ !== (want != 8'h00)) begin
                errors++;
                $display("FAIL rand_step%0d got %h/%b want %h/%b", n, IRR, INT_REQ, want, want != 8'h00);
            end
            // Mask changes between edges show up without a clock.
            Mask = 8'($urandom);
            #1;
            want = exp_irr();
            checks++;
            if (IRR !== want) begin errors++; $display("FAIL rand_mask%0d got %h want %h", n, IRR, want); end
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (IRR !== 8'h00 || INT_REQ !== 1'b0) begin
                    errors++; $display("FAIL rand_async_reset got %h/%b want 00/0", IRR, INT_REQ);
                end
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_edge_held();
        test_collision();
        test_mask_live();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
